spi_dac_tx: RTL and testbench
=============================

// Module: spi_dac_tx
// PURPOSE
//  Serial DAC transmitter, the output-side counterpart of the smpladc serial ADC receiver.
//  Accepts 12b unsigned samples over a valid/ready handshake and clocks each out as one
//  16b SPI mode-0 frame (MCP4921-style: 4 config bits + 12 data bits, MSB first).
//  Each frame ends with an LDAC latch pulse. Runs on pixclk beside the ADC and sdft
//  path, for audio/test-tone output.
// PARAMETERS
//  SAMPLE_WIDTH  12       data bits per frame; fixed at 12 because FRAME_W = 4 + SAMPLE_WIDTH
//  HALF          5        clk cycles per SCK half-period, >= 1
//                         (HALF = 5 gives 2 MHz SCK at 20 MHz clk)
//  CONFIG        4'b0011  frame bits [15:12]: A/B=0, BUF=0, GA=1 (1x), SHDN=1 (active)
// PORTS
//  clk      in   1   pixel clock, all logic on posedge
//  resetn   in   1   asynchronous active-low reset
//  i_data   in   12  unsigned sample, straight binary
//  i_valid  in   1   i_data valid; producer holds i_data stable until accepted
//  o_ready  out  1   block idle and can accept a sample
//  o_busy   out  1   frame in progress; equals ~o_ready after reset
//  o_csn    out  1   DAC chip select, active low
//  o_sck    out  1   serial clock, idles low
//  o_mosi   out  1   serial data; changes on SCK falling edge, stable at the rising edge
//  o_ldacn  out  1   DAC latch strobe, active low
// BEHAVIOUR
//  Reset (async, immediate, including mid-frame):
//   - o_csn=1, o_sck=0, o_mosi=0, o_ldacn=1, o_ready=0, o_busy=0, state=IDLE.
//   - o_ready rises on the first clk edge after resetn deasserts.
//  Handshake:
//   - A sample is accepted on a clk edge where i_valid && o_ready.
//   - On acceptance: shift register <= {CONFIG, i_data}; o_ready <= 0; o_busy <= 1.
//   - i_valid while busy is ignored. There is no buffering and no sample is dropped silently:
//     the producer must hold i_valid until o_ready.
//  FSM; phase counter counts 0..HALF-1, and each state below lasts HALF cycles unless noted:
//   - IDLE: o_csn=1, o_sck=0. Leaves on acceptance.
//   - SETUP: o_csn=0, o_sck=0, o_mosi=bit15.
//   - SCK_HI: o_sck=1. After the 16th SCK_HI go to HOLD, otherwise go to SCK_LO.
//   - SCK_LO: o_sck=0; shift register shifts left on entry, so o_mosi shows the next bit.
//   - HOLD: o_sck=0, o_csn still 0. Then o_csn=1.
//   - LATCH: o_csn=1, o_ldacn=0.
//   - GAP: o_ldacn=1, o_mosi=0. Then IDLE with o_ready=1.
//  Timing:
//   - Frame length 35*HALF clk from the acceptance edge to o_ready re-rising (175 at HALF=5).
//   - o_csn low for 33*HALF cycles.
//   - Exactly 16 SCK rising edges per o_csn-low window.
//   - Bit count is a 5b counter; it must not wrap (counts 0..16).
//  Outputs: all are registered (no comb glitches on pins). o_busy = ~o_ready out of reset.
//  Edge cases:
//   - HALF=1 is legal: SCK toggles every clk and the frame is 35 cycles.
//   - i_valid held high continuously gives back-to-back frames with period 35*HALF+1 cycles:
//     the IDLE accept cycle plus the frame.
// STRUCTURE
//  - spi_dac_defs.vh (`include): FRAME_W=16, CONFIG default, state encodings
//    IDLE/SETUP/SCK_HI/SCK_LO/HOLD/LATCH/GAP.
//  - Sub-module: spi_phase_timer. Parameterised by HALF; emits a one-cycle 'tick' at
//    phase HALF-1 and restarts on 'start'. The FSM advances only on tick.
//  - Top-level integration: instantiated in top.v on pixclk with resetn=locked; fed from a
//    tone/sample source.
// TESTING
//  1. Reset, HALF=5, present 12'hA5C with i_valid.
//     -> Bits captured on SCK rising edges = 16'h3A5C. o_csn low 165 cycles.
//     -> o_ldacn low 5 cycles right after o_csn rises. o_ready back 175 cycles after acceptance.
//  2. i_valid held high with 12'h123 then 12'h456.
//     -> Two frames 16'h3123 and 16'h3456, accept edges 176 cycles apart.
//     -> o_csn high >= 10 cycles between frames.
//  3. Change i_data every cycle while o_busy=1.
//     -> Frame content unaffected. The next frame carries exactly the value present on the
//        cycle o_ready && i_valid.
//  4. Assert resetn low after the 7th SCK rising edge.
//     -> Same cycle: o_csn=1, o_sck=0, o_ldacn=1, o_mosi=0.
//     -> After release, the next sample 12'h800 produces a complete, correct 16'h3800 frame.
//  5. HALF=1 with data 12'h000 then 12'hFFF.
//     -> Frames 16'h3000 and 16'h3FFF, 35 cycles each. SCK toggles every clk during shift.
//  6. Protocol checker on all runs.
//     -> o_mosi never changes while o_sck=1; 16 rising edges per o_csn-low window.
//     -> o_ldacn low only while o_csn=1; o_sck=0 whenever o_csn=1.

Source files
------------

// File: rtl/spi_dac_pkg.sv
// spi_dac_pkg: shared frame constants and FSM state encoding for the SPI DAC transmitter.
package spi_dac_pkg;
    localparam int         SAMPLE_W       = 12;
    localparam int         FRAME_W        = 16;
    localparam logic [3:0] CONFIG_DEFAULT = 4'b0011;
    localparam logic [4:0] LAST_BIT       = 5'(FRAME_W);
    typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, LATCH, GAP} state_t;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: counts 0..HALF-1 and ticks on the last phase; restarts on i_start.
module spi_phase_timer #(
    parameter int HALF = 5
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_start,
    output logic o_tick
);
    localparam int            PW   = HALF > 1 ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] LAST = PW'(HALF - 1);
    logic [PW-1:0] r_phase;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            r_phase <= '0;
        else
            r_phase <= (i_start || r_phase == LAST) ? '0 : r_phase + 1'b1;
    assign o_tick = r_phase == LAST;
endmodule

// File: rtl/spi_dac_tx.sv
// spi_dac_tx: takes 12b samples over valid/ready and shifts each out as a 16b SPI mode-0
// DAC frame (config nibble + data, MSB first), followed by an LDAC latch pulse.
module spi_dac_tx
    import spi_dac_pkg::*;
#(
    parameter int         SAMPLE_WIDTH = SAMPLE_W,
    parameter int         HALF         = 5,
    parameter logic [3:0] CONFIG       = CONFIG_DEFAULT
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [SAMPLE_WIDTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_busy,
    output logic                    o_csn,
    output logic                    o_sck,
    output logic                    o_mosi,
    output logic                    o_ldacn
);
    localparam int FW = 4 + SAMPLE_WIDTH;
    state_t          r_state, w_state;
    logic [FW-1:0]   r_sr, w_sr;
    logic [4:0]      r_cnt, w_cnt;
    logic            r_csn, w_csn, r_sck, w_sck, r_mosi, w_mosi;
    logic            r_ldacn, w_ldacn, r_ready, w_ready, r_busy, w_busy;
    logic            w_accept, w_tick;
    assign w_accept = i_valid && r_ready;
    spi_phase_timer #(.HALF(HALF)) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .i_start (w_accept),
        .o_tick  (w_tick)
    );
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_csn   <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_ldacn <= 1'b1;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_sr    <= w_sr;
            r_cnt   <= w_cnt;
            r_csn   <= w_csn;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
            r_ldacn <= w_ldacn;
            r_ready <= w_ready;
            r_busy  <= w_busy;
        end
    // Next values of every pin are computed here so the pins themselves come straight from flops.
    always_comb begin
        w_state = r_state;
        w_sr    = r_sr;
        w_cnt   = r_cnt;
        w_csn   = r_csn;
        w_sck   = r_sck;
        w_mosi  = r_mosi;
        w_ldacn = r_ldacn;
        w_ready = r_ready;
        w_busy  = r_busy;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (w_accept) begin
                    w_state = SETUP;
                    w_sr    = {CONFIG, i_data};
                    w_cnt   = '0;
                    w_csn   = 1'b0;
                    w_mosi  = CONFIG[3];
                    w_ready = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            SETUP, SCK_LO:
                if (w_tick) begin
                    w_state = SCK_HI;
                    w_sck   = 1'b1;
                    w_cnt   = r_cnt + 5'd1;
                end
            SCK_HI:
                if (w_tick) begin
                    w_sck   = 1'b0;
                    w_state = (r_cnt == LAST_BIT) ? HOLD : SCK_LO;
                    if (r_cnt != LAST_BIT) begin
                        w_sr   = {r_sr[FW-2:0], 1'b0};
                        w_mosi = r_sr[FW-2];
                    end
                end
            HOLD:
                if (w_tick) begin
                    w_state = LATCH;
                    w_csn   = 1'b1;
                    w_ldacn = 1'b0;
                end
            LATCH:
                if (w_tick) begin
                    w_state = GAP;
                    w_ldacn = 1'b1;
                    w_mosi  = 1'b0;
                end
            GAP:
                if (w_tick) begin
                    w_state = IDLE;
                    w_ready = 1'b1;
                    w_busy  = 1'b0;
                end
            default: w_state = IDLE;
        endcase
    end
    assign o_ready = r_ready;
    assign o_busy  = r_busy;
    assign o_csn   = r_csn;
    assign o_sck   = r_sck;
    assign o_mosi  = r_mosi;
    assign o_ldacn = r_ldacn;
endmodule

// File: tb/tb_spi_dac_tx.sv
// tb_spi_dac_tx: drives a HALF=5 and a HALF=1 instance; a pin monitor rebuilds each frame
// and its timing, and the test tasks compare them against frame rules computed here.
module tb_spi_dac_tx;
    localparam int H0 = 5;
    localparam int H1 = 1;
    typedef struct {
        int          k;
        logic [15:0] w;
        int          nr;
        int          cl;
        int          ll;
        int          off;
        int          shi;
        int          gap;
    } fr_t;
    logic        clk = 1'b0;
    logic [1:0]  rst, vld, rdy, busy, csn, sck, mosi, ldac;
    logic [11:0] din [2];
    int          checks = 0;
    int          errors = 0;
    int          perr [2];
    fr_t         fq [$];
    always #5 clk = ~clk;
    spi_dac_tx #(.HALF(H0)) u0 (
        .clk(clk), .resetn(rst[0]), .i_data(din[0]), .i_valid(vld[0]), .o_ready(rdy[0]),
        .o_busy(busy[0]), .o_csn(csn[0]), .o_sck(sck[0]), .o_mosi(mosi[0]), .o_ldacn(ldac[0])
    );
    spi_dac_tx #(.HALF(H1)) u1 (
        .clk(clk), .resetn(rst[1]), .i_data(din[1]), .i_valid(vld[1]), .o_ready(rdy[1]),
        .o_busy(busy[1]), .o_csn(csn[1]), .o_sck(sck[1]), .o_mosi(mosi[1]), .o_ldacn(ldac[1])
    );
    function automatic logic [15:0] model(input logic [11:0] d);
        return {4'b0011, d};
    endfunction
    // Pin monitor: one record per completed csn-low window plus its LDAC pulse.
    logic [15:0] cap [2];
    int          nr [2], cl [2], ll [2], off [2], shi [2], run [2], hi [2], gap [2];
    bit          win [2];
    logic [1:0]  p_csn, p_sck, p_mosi, p_ldac;
    fr_t         mf;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst[k]) begin
                win[k] = 0;
                hi[k]  = 0;
            end else begin
                if (!csn[k] && p_csn[k]) begin
                    win[k] = 1; cap[k] = '0; nr[k] = 0; cl[k] = 0; ll[k] = 0;
                    off[k] = -1; shi[k] = 0; run[k] = 0; gap[k] = hi[k] + 1;
                end
                if (csn[k] && !p_csn[k]) hi[k] = 0;
                else if (csn[k]) hi[k]++;
                if (!csn[k]) cl[k]++;
                run[k] = sck[k] ? run[k] + 1 : 0;
                if (run[k] > shi[k]) shi[k] = run[k];
                if (sck[k] && !p_sck[k]) begin
                    cap[k] = {cap[k][14:0], mosi[k]};
                    nr[k]++;
                end
                if ((sck[k] && mosi[k] !== p_mosi[k]) || (csn[k] && sck[k]) || (!ldac[k] && !csn[k]))
                    perr[k]++;
                if (!ldac[k] && p_ldac[k]) off[k] = hi[k];
                if (!ldac[k]) ll[k]++;
                if (ldac[k] && !p_ldac[k] && win[k]) begin
                    mf.k = k; mf.w = cap[k]; mf.nr = nr[k]; mf.cl = cl[k]; mf.ll = ll[k];
                    mf.off = off[k]; mf.shi = shi[k]; mf.gap = gap[k];
                    fq.push_back(mf);
                    win[k] = 0;
                end
            end
            p_csn[k] = csn[k]; p_sck[k] = sck[k]; p_mosi[k] = mosi[k]; p_ldac[k] = ldac[k];
        end
    end
    task automatic send(input int k, input logic [11:0] d, input bit hold, output longint t);
        int n = 0;
        @(negedge clk);
        din[k] = d;
        vld[k] = 1'b1;
        while (!rdy[k] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rdy[k] !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout k=%0d o_ready=%b required 1", k, rdy[k]);
        end
        t = $time + 10;
        @(negedge clk);
        if (!hold) vld[k] = 1'b0;
    endtask
    task automatic wait_ready(input int k, input longint t0, output int c);
        int n = 0;
        while (!rdy[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        c = rdy[k] ? int'(($time - t0) / 10) : -1;
    endtask
    task automatic get_frame(output fr_t f);
        int n = 0;
        while (fq.size() == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (fq.size() > 0) f = fq.pop_front();
        else begin
            f.k = -1; f.w = 'x; f.nr = -1; f.cl = -1; f.ll = -1; f.off = -1; f.shi = -1; f.gap = -1;
        end
    endtask
    task automatic test_reset();
        rst = 2'b00; vld = 2'b00; din[0] = '0; din[1] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({csn[k], sck[k], ldac[k], mosi[k], rdy[k], busy[k]} !== 6'b101000) begin
                errors++;
                $display("FAIL reset_pins k=%0d csn,sck,ldacn,mosi,ready,busy=%b required 101000", k,
                         {csn[k], sck[k], ldac[k], mosi[k], rdy[k], busy[k]});
            end
        end
        rst = 2'b11;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({rdy[k], busy[k]} !== 2'b10) begin
                errors++;
                $display("FAIL reset_release k=%0d ready,busy=%b required 10", k, {rdy[k], busy[k]});
            end
        end
    endtask
    task automatic test_single();
        longint t;
        int     c;
        fr_t    f;
        send(0, 12'hA5C, 0, t);
        wait_ready(0, t, c);
        get_frame(f);
        checks += 7;
        if (f.w !== model(12'hA5C)) begin errors++; $display("FAIL single_word got %h required %h", f.w, model(12'hA5C)); end
        if (f.nr !== 16) begin errors++; $display("FAIL single_rises got %0d required 16", f.nr); end
        if (f.cl !== 33 * H0) begin errors++; $display("FAIL single_csn_low got %0d required %0d", f.cl, 33 * H0); end
        if (f.ll !== H0) begin errors++; $display("FAIL single_ldac_low got %0d required %0d", f.ll, H0); end
        if (f.off !== 0) begin errors++; $display("FAIL single_ldac_offset got %0d required 0", f.off); end
        if (f.shi !== H0) begin errors++; $display("FAIL single_sck_high got %0d required %0d", f.shi, H0); end
        if (c !== 35 * H0) begin errors++; $display("FAIL single_ready_delay got %0d required %0d", c, 35 * H0); end
    endtask
    task automatic test_random();
        longint      t;
        int          c;
        fr_t         f;
        logic [11:0] d;
        repeat (4) begin
            d = 12'($urandom);
            send(0, d, 0, t);
            wait_ready(0, t, c);
            get_frame(f);
            checks += 2;
            if (f.w !== model(d)) begin errors++; $display("FAIL random_word got %h required %h", f.w, model(d)); end
            if (c !== 35 * H0) begin errors++; $display("FAIL random_ready_delay got %0d required %0d", c, 35 * H0); end
        end
    endtask
    task automatic test_back_to_back();
        longint t1, t2;
        int     c;
        fr_t    f1, f2;
        send(0, 12'h123, 1, t1);
        send(0, 12'h456, 0, t2);
        wait_ready(0, t2, c);
        get_frame(f1);
        get_frame(f2);
        checks += 4;
        if (f1.w !== 16'h3123) begin errors++; $display("FAIL b2b_word1 got %h required 3123", f1.w); end
        if (f2.w !== 16'h3456) begin errors++; $display("FAIL b2b_word2 got %h required 3456", f2.w); end
        if ((t2 - t1) / 10 !== longint'(35 * H0 + 1)) begin
            errors++; $display("FAIL b2b_period got %0d required %0d", (t2 - t1) / 10, 35 * H0 + 1);
        end
        if (f2.gap !== 2 * H0 + 1) begin errors++; $display("FAIL b2b_csn_gap got %0d required %0d", f2.gap, 2 * H0 + 1); end
    endtask
    task automatic test_busy_data();
        longint      t;
        int          c, n;
        fr_t         f1, f2;
        logic [11:0] d0, x, exp2;
        d0 = 12'($urandom);
        exp2 = 'x;
        send(0, d0, 1, t);
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            x = 12'($urandom);
            din[0] = x;
            n++;
            if (rdy[0]) begin
                exp2 = x;
                break;
            end
        end
        @(negedge clk);
        vld[0] = 1'b0;
        din[0] = 12'($urandom);
        wait_ready(0, $time, c);
        get_frame(f1);
        get_frame(f2);
        checks += 2;
        if (f1.w !== model(d0)) begin errors++; $display("FAIL busy_word1 got %h required %h", f1.w, model(d0)); end
        if (f2.w !== model(exp2)) begin errors++; $display("FAIL busy_word2 got %h required %h", f2.w, model(exp2)); end
    endtask
    task automatic test_reset_mid();
        longint t;
        int     c, n, g;
        fr_t    f;
        logic   prev;
        send(0, 12'($urandom), 0, t);
        prev = sck[0];
        n = 0;
        g = 0;
        while (n < 7 && g < 2000) begin
            @(negedge clk);
            if (sck[0] && !prev) n++;
            prev = sck[0];
            g++;
        end
        #1 rst[0] = 1'b0;
        #1;
        checks += 2;
        if ({csn[0], sck[0], ldac[0], mosi[0], rdy[0], busy[0]} !== 6'b101000) begin
            errors++;
            $display("FAIL midreset_pins csn,sck,ldacn,mosi,ready,busy=%b required 101000",
                     {csn[0], sck[0], ldac[0], mosi[0], rdy[0], busy[0]});
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b1;
        if (fq.size() !== 0) begin errors++; $display("FAIL midreset_partial frames=%0d required 0", fq.size()); end
        send(0, 12'h800, 0, t);
        wait_ready(0, t, c);
        get_frame(f);
        checks += 3;
        if (f.w !== 16'h3800) begin errors++; $display("FAIL midreset_word got %h required 3800", f.w); end
        if (f.nr !== 16) begin errors++; $display("FAIL midreset_rises got %0d required 16", f.nr); end
        if (c !== 35 * H0) begin errors++; $display("FAIL midreset_ready_delay got %0d required %0d", c, 35 * H0); end
    endtask
    task automatic test_half1();
        logic [11:0] hv [2];
        longint      t;
        int          c;
        fr_t         f;
        hv[0] = 12'h000;
        hv[1] = 12'hFFF;
        for (int i = 0; i < 2; i++) begin
            send(1, hv[i], 0, t);
            wait_ready(1, t, c);
            get_frame(f);
            checks += 6;
            if (f.w !== model(hv[i])) begin errors++; $display("FAIL half1_word got %h required %h", f.w, model(hv[i])); end
            if (c !== 35 * H1) begin errors++; $display("FAIL half1_ready_delay got %0d required %0d", c, 35 * H1); end
            if (f.cl !== 33 * H1) begin errors++; $display("FAIL half1_csn_low got %0d required %0d", f.cl, 33 * H1); end
            if (f.nr !== 16) begin errors++; $display("FAIL half1_rises got %0d required 16", f.nr); end
            if (f.shi !== H1) begin errors++; $display("FAIL half1_sck_high got %0d required %0d", f.shi, H1); end
            if (f.ll !== H1) begin errors++; $display("FAIL half1_ldac_low got %0d required %0d", f.ll, H1); end
        end
    endtask
    task automatic test_protocol();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (perr[k] !== 0) begin errors++; $display("FAIL protocol k=%0d violations=%0d required 0", k, perr[k]); end
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_busy_data();
        test_reset_mid();
        test_half1();
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
